// File: rtl/cu_alu_ex_mem.sv
// cu_alu_ex_mem: MIPS execute slice (decode, ALU, EX/MEM register); define MULDIV_EN for mult/multu/mfhi/mflo and Hi/Lo.
module cu_alu_ex_mem (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [5:0]  OPcode,
    input  logic [5:0]  Func,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] immediate,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic        jump,
    output logic        EX_MEM_MemWrite,
    output logic        EX_MEM_MemRead,
    output logic        EX_MEM_Branch,
    output logic        EX_MEM_Jump,
    output logic        EX_MEM_MemtoReg,
    output logic        EX_MEM_RegWrite,
    output logic [31:0] EX_MEM_PC,
    output logic [31:0] EX_MEM_ALU_RESULT,
    output logic [2:0]  EX_MEM_ALU_SIGN,
    output logic [31:0] EX_MEM_MEM_WDATA,
    output logic [4:0]  EX_MEM_REG_WADDR,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                           OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SLT = 5'd6, OP_SLTU = 5'd7,
                           OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_LUI = 5'd11,
                           OP_MULT = 5'd12, OP_MULTU = 5'd13, OP_MFHI = 5'd14, OP_MFLO = 5'd15;
    logic [4:0]  w_op;
    logic        w_regdst, w_alusrc, w_zext, w_ovf_en;
    logic        w_memread, w_memwrite, w_memtoreg, w_regwrite, w_branch, w_jump;
    logic [31:0] w_b, w_sum, w_diff, w_res;
    logic        w_over;
    always_comb begin
        w_op = OP_ADD;
        w_regdst = 1'b0;
        w_alusrc = 1'b0;
        w_zext = 1'b0;
        w_ovf_en = 1'b0;
        w_memread = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_branch = 1'b0;
        w_jump = 1'b0;
        case (OPcode)
            6'h00: begin
                w_regdst = 1'b1;
                w_regwrite = 1'b1;
                case (Func)
                    6'h20: begin w_op = OP_ADD; w_ovf_en = 1'b1; end
                    6'h21: w_op = OP_ADD;
                    6'h22: begin w_op = OP_SUB; w_ovf_en = 1'b1; end
                    6'h23: w_op = OP_SUB;
                    6'h24: w_op = OP_AND;
                    6'h25: w_op = OP_OR;
                    6'h26: w_op = OP_XOR;
                    6'h27: w_op = OP_NOR;
                    6'h2A: w_op = OP_SLT;
                    6'h2B: w_op = OP_SLTU;
                    6'h00: w_op = OP_SLL;
                    6'h02: w_op = OP_SRL;
                    6'h03: w_op = OP_SRA;
`ifdef MULDIV_EN
                    6'h18: begin w_op = OP_MULT; w_regwrite = 1'b0; end
                    6'h19: begin w_op = OP_MULTU; w_regwrite = 1'b0; end
                    6'h10: w_op = OP_MFHI;
                    6'h12: w_op = OP_MFLO;
`endif
                    default: begin w_regdst = 1'b0; w_regwrite = 1'b0; end
                endcase
            end
            6'h08: begin w_alusrc = 1'b1; w_regwrite = 1'b1; w_ovf_en = 1'b1; end
            6'h09: begin w_alusrc = 1'b1; w_regwrite = 1'b1; end
            6'h0A: begin w_op = OP_SLT; w_alusrc = 1'b1; w_regwrite = 1'b1; end
            6'h0C: begin w_op = OP_AND; w_alusrc = 1'b1; w_zext = 1'b1; w_regwrite = 1'b1; end
            6'h0D: begin w_op = OP_OR; w_alusrc = 1'b1; w_zext = 1'b1; w_regwrite = 1'b1; end
            6'h0E: begin w_op = OP_XOR; w_alusrc = 1'b1; w_zext = 1'b1; w_regwrite = 1'b1; end
            6'h0F: begin w_op = OP_LUI; w_alusrc = 1'b1; w_regwrite = 1'b1; end
            6'h23: begin w_alusrc = 1'b1; w_memread = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1; end
            6'h2B: begin w_alusrc = 1'b1; w_memwrite = 1'b1; end
            6'h04: begin w_op = OP_SUB; w_branch = 1'b1; end
            6'h02: w_jump = 1'b1;
            default: ;
        endcase
    end
    assign jump   = w_jump;
    assign w_b    = w_alusrc ? (w_zext ? {16'b0, immediate[15:0]} : immediate) : rdata2;
    assign w_sum  = rdata1 + w_b;
    assign w_diff = rdata1 - w_b;
    // overflow only when operands agree (add) / disagree (sub) in sign and the result flips
    assign w_over = w_ovf_en & ((w_op == OP_SUB) ? (rdata1[31] != w_b[31]) && (w_diff[31] != rdata1[31])
                                                 : (rdata1[31] == w_b[31]) && (w_sum[31] != rdata1[31]));
    always_comb begin
        case (w_op)
            OP_SUB:  w_res = w_diff;
            OP_AND:  w_res = rdata1 & w_b;
            OP_OR:   w_res = rdata1 | w_b;
            OP_XOR:  w_res = rdata1 ^ w_b;
            OP_NOR:  w_res = ~(rdata1 | w_b);
            OP_SLT:  w_res = {31'b0, $signed(rdata1) < $signed(w_b)};
            OP_SLTU: w_res = {31'b0, rdata1 < w_b};
            OP_SLL:  w_res = rdata2 << immediate[10:6];
            OP_SRL:  w_res = rdata2 >> immediate[10:6];
            OP_SRA:  w_res = $signed(rdata2) >>> immediate[10:6];
            OP_LUI:  w_res = {immediate[15:0], 16'b0};
            OP_MFHI: w_res = hi;
            OP_MFLO: w_res = lo;
            default: w_res = w_sum;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_Branch     <= 1'b0;
            EX_MEM_Jump       <= 1'b0;
            EX_MEM_MemtoReg   <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_PC         <= 32'b0;
            EX_MEM_ALU_RESULT <= 32'b0;
            EX_MEM_ALU_SIGN   <= 3'b0;
            EX_MEM_MEM_WDATA  <= 32'b0;
            EX_MEM_REG_WADDR  <= 5'b0;
        end else if (en) begin
            EX_MEM_MemWrite   <= w_memwrite;
            EX_MEM_MemRead    <= w_memread;
            EX_MEM_Branch     <= w_branch;
            EX_MEM_Jump       <= w_jump;
            EX_MEM_MemtoReg   <= w_memtoreg;
            EX_MEM_RegWrite   <= w_regwrite;
            EX_MEM_PC         <= pc_plus4 + {immediate[29:0], 2'b00};
            EX_MEM_ALU_RESULT <= w_res;
            EX_MEM_ALU_SIGN   <= {w_res == 32'b0, w_over, w_res[31]};
            EX_MEM_MEM_WDATA  <= rdata2;
            EX_MEM_REG_WADDR  <= w_regdst ? rd_addr : rt_addr;
        end
    end
`ifdef MULDIV_EN
    logic        w_sx;
    logic [63:0] w_prod;
    assign w_sx   = (w_op == OP_MULT);
    // sign-extending then multiplying mod 2^64 yields the signed product
    assign w_prod = {{32{w_sx & rdata1[31]}}, rdata1} * {{32{w_sx & rdata2[31]}}, rdata2};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= 32'b0;
            lo <= 32'b0;
        end else if (en && (w_op == OP_MULT || w_op == OP_MULTU)) begin
            hi <= w_prod[63:32];
            lo <= w_prod[31:0];
        end
    end
`else
    assign hi = 32'b0;
    assign lo = 32'b0;
`endif
endmodule

// File: tb/tb_cu_alu_ex_mem.sv
// tb_cu_alu_ex_mem: directed self-checking bench for cu_alu_ex_mem.
module tb_cu_alu_ex_mem;
    logic        clk, reset_n, en;
    logic [5:0]  OPcode, Func;
    logic [31:0] rdata1, rdata2, immediate, pc_plus4;
    logic [4:0]  rt_addr, rd_addr;
    logic        jump, mw, mr, br, jp, m2r, rw;
    logic [31:0] pc, res, wdata, hi, lo;
    logic [2:0]  sgn;
    logic [4:0]  waddr;
    int n_cmp = 0, n_err = 0;
    cu_alu_ex_mem dut (
        .clk(clk), .reset_n(reset_n), .en(en), .OPcode(OPcode), .Func(Func),
        .rdata1(rdata1), .rdata2(rdata2), .immediate(immediate), .pc_plus4(pc_plus4),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .jump(jump),
        .EX_MEM_MemWrite(mw), .EX_MEM_MemRead(mr), .EX_MEM_Branch(br), .EX_MEM_Jump(jp),
        .EX_MEM_MemtoReg(m2r), .EX_MEM_RegWrite(rw), .EX_MEM_PC(pc),
        .EX_MEM_ALU_RESULT(res), .EX_MEM_ALU_SIGN(sgn), .EX_MEM_MEM_WDATA(wdata),
        .EX_MEM_REG_WADDR(waddr), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] p,
                         input logic [4:0] rt, input logic [4:0] rd);
        OPcode = op; Func = fn; rdata1 = a; rdata2 = b; immediate = imm; pc_plus4 = p;
        rt_addr = rt; rd_addr = rd;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        clk = 0; reset_n = 0; en = 1;
        drive(6'h00, 6'h20, 32'd5, 32'd7, 32'd0, 32'd0, 5'd9, 5'd3);
        #1;
        check("rst_result", res, 32'h0);
        check("rst_regwrite", {31'b0, rw}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_waddr", {27'b0, waddr}, 32'h0);
        check("rst_hi", hi, 32'h0);
        @(posedge clk);
        #2 reset_n = 1;
        step();
        check("add_result", res, 32'd12);
        check("add_sign", {29'b0, sgn}, 32'h0);
        check("add_waddr", {27'b0, waddr}, 32'd3);
        check("add_regwrite", {31'b0, rw}, 32'h1);
        drive(6'h08, 6'h00, 32'h7FFFFFFF, 32'h0, 32'd1, 32'd0, 5'd4, 5'd3);
        step();
        check("addi_result", res, 32'h80000000);
        check("addi_sign", {29'b0, sgn}, 32'h3);
        check("addi_waddr", {27'b0, waddr}, 32'd4);
        check("addi_regwrite", {31'b0, rw}, 32'h1);
        drive(6'h04, 6'h00, 32'd9, 32'd9, 32'd4, 32'h100, 5'd1, 5'd2);
        step();
        check("beq_zero", {31'b0, sgn[2]}, 32'h1);
        check("beq_branch", {31'b0, br}, 32'h1);
        check("beq_pc", pc, 32'h110);
        check("beq_regwrite", {31'b0, rw}, 32'h0);
        drive(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd1, 5'd5);
        step();
        check("slt_result", res, 32'd1);
        drive(6'h00, 6'h2B, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd1, 5'd5);
        step();
        check("sltu_result", res, 32'd0);
        check("sltu_sign", {29'b0, sgn}, 32'h4);
        drive(6'h00, 6'h03, 32'h0, 32'h80000000, 32'h100, 32'd0, 5'd1, 5'd6);
        step();
        check("sra_result", res, 32'hF8000000);
        drive(6'h00, 6'h02, 32'h0, 32'h80000000, 32'h100, 32'd0, 5'd1, 5'd6);
        step();
        check("srl_result", res, 32'h08000000);
        drive(6'h00, 6'h22, 32'h80000000, 32'd1, 32'd0, 32'd0, 5'd1, 5'd6);
        step();
        check("sub_ovf_sign", {29'b0, sgn}, 32'h2);
        drive(6'h0D, 6'h00, 32'hF0000000, 32'h0, 32'hFFFF8001, 32'd0, 5'd8, 5'd6);
        step();
        check("ori_result", res, 32'hF0008001);
        drive(6'h0F, 6'h00, 32'h0, 32'h0, 32'h00001234, 32'd0, 5'd8, 5'd6);
        step();
        check("lui_result", res, 32'h12340000);
        drive(6'h00, 6'h18, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 5'd1, 5'd2);
        step();
        check("mult_regwrite", {31'b0, rw}, 32'h0);
`ifdef MULDIV_EN
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        drive(6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2);
        step();
        check("mflo_result", res, 32'hFFFFFFFA);
`else
        check("mult_hi", hi, 32'h0);
        check("mult_result", res, 32'h1);
`endif
        drive(6'h2B, 6'h00, 32'h1000, 32'hDEAD, 32'd8, 32'd0, 5'd1, 5'd2);
        step();
        check("sw_result", res, 32'h1008);
        check("sw_memwrite", {31'b0, mw}, 32'h1);
        check("sw_wdata", wdata, 32'hDEAD);
        check("sw_regwrite", {31'b0, rw}, 32'h0);
        drive(6'h23, 6'h00, 32'h2000, 32'h0, 32'd4, 32'd0, 5'd7, 5'd2);
        step();
        check("lw_result", res, 32'h2004);
        check("lw_memread", {31'b0, mr}, 32'h1);
        check("lw_memtoreg", {31'b0, m2r}, 32'h1);
        check("lw_waddr", {27'b0, waddr}, 32'd7);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            drive(6'h00, 6'h20, 32'd100 + i, 32'd1, 32'd0, 32'd0, 5'd11, 5'd12);
            step();
        end
        check("hold_result", res, 32'h2004);
        check("hold_memread", {31'b0, mr}, 32'h1);
        check("hold_waddr", {27'b0, waddr}, 32'd7);
        drive(6'h02, 6'h00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check("j_comb", {31'b0, jump}, 32'h1);
        en = 1;
        step();
        check("j_reg", {31'b0, jp}, 32'h1);
        drive(6'h3F, 6'h00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd3, 5'd4);
        step();
        check("unk_regwrite", {31'b0, rw}, 32'h0);
        check("unk_result", res, 32'd30);
        check("unk_jump", {31'b0, jp}, 32'h0);
        drive(6'h23, 6'h00, 32'h3000, 32'h0, 32'd4, 32'd0, 5'd7, 5'd2);
        step();
        check("lw2_result", res, 32'h3004);
        #2 reset_n = 0;
        #1;
        check("arst_result", res, 32'h0);
        check("arst_memread", {31'b0, mr}, 32'h0);
        check("arst_waddr", {27'b0, waddr}, 32'h0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
